// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths and exponent helpers for the fp zero-detect pipe
package fp_pkg;

    localparam int DEF_EXP_W  = 4;
    localparam int DEF_MANT_W = 5;
    localparam int DEF_CNT_W  = 8;

    // All-ones pattern of the low w bits; marks inf/NaN exponents.
    function automatic logic [31:0] exp_all_ones(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_zero_detect_pipe_if.sv
// rtl/fp_zero_detect_pipe_if.sv - operand/flag handshake bundle for fp_zero_detect_pipe
interface fp_zero_detect_pipe_if #(
    parameter int EXP_W  = fp_pkg::DEF_EXP_W,
    parameter int MANT_W = fp_pkg::DEF_MANT_W,
    parameter int CNT_W  = fp_pkg::DEF_CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic              sign_a;
    logic              sign_b;
    logic              funct;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic              out_valid;
    logic              out_ready;
    logic              zero;
    logic              eff_sub;
    logic              a_is_zero;
    logic              b_is_zero;
    logic              special;
    logic              clr_count;
    logic [CNT_W-1:0]  zero_count;

    modport master (
        output in_valid, sign_a, sign_b, funct, exp_a, exp_b, mant_a, mant_b,
        output out_ready, clr_count,
        input  in_ready, out_valid, zero, eff_sub, a_is_zero, b_is_zero, special,
        input  zero_count
    );

    modport slave (
        input  in_valid, sign_a, sign_b, funct, exp_a, exp_b, mant_a, mant_b,
        input  out_ready, clr_count,
        output in_ready, out_valid, zero, eff_sub, a_is_zero, b_is_zero, special,
        output zero_count
    );

endinterface

// File: rtl/fp_operand_classify.sv
// rtl/fp_operand_classify.sv - flags one operand as zero or inf/NaN
module fp_operand_classify
    import fp_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MANT_W = DEF_MANT_W
) (
    input  logic [EXP_W-1:0]  exp_field,
    input  logic [MANT_W-1:0] mant_field,
    output logic              is_zero,
    output logic              is_special
);

    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_all_ones(EXP_W));

    assign is_zero    = (exp_field == '0) && (mant_field == '0);
    assign is_special = (exp_field == EXP_ONES);

endmodule

// File: rtl/fp_zero_detect_pipe.sv
// rtl/fp_zero_detect_pipe.sv - two-stage exact-zero predictor for fp add/sub with result counter
module fp_zero_detect_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MANT_W = DEF_MANT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_zero_detect_pipe_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic a_zero, b_zero, a_special, b_special;

    fp_operand_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
        .exp_field  (bus.exp_a),
        .mant_field (bus.mant_a),
        .is_zero    (a_zero),
        .is_special (a_special)
    );

    fp_operand_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
        .exp_field  (bus.exp_b),
        .mant_field (bus.mant_b),
        .is_zero    (b_zero),
        .is_special (b_special)
    );

    logic s1_valid, s1_a_zero, s1_b_zero, s1_special, s1_eff_sub, s1_match;
    logic adv2, adv1, out_xfer;

    // No skid buffer: backpressure ripples straight through to in_ready.
    assign adv2         = !bus.out_valid || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1;
    assign out_xfer     = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a_zero  <= 1'b0;
            s1_b_zero  <= 1'b0;
            s1_special <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_match   <= 1'b0;
        end else if (adv1) begin
            s1_valid   <= bus.in_valid;
            s1_a_zero  <= a_zero;
            s1_b_zero  <= b_zero;
            s1_special <= a_special || b_special;
            s1_eff_sub <= bus.sign_a ^ bus.sign_b ^ bus.funct;
            s1_match   <= (bus.exp_a == bus.exp_b) && (bus.mant_a == bus.mant_b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.zero      <= 1'b0;
            bus.eff_sub   <= 1'b0;
            bus.a_is_zero <= 1'b0;
            bus.b_is_zero <= 1'b0;
            bus.special   <= 1'b0;
        end else if (adv2) begin
            bus.out_valid <= s1_valid;
            // Equal magnitudes cancel only under effective subtraction; 0 +/- 0 is always zero.
            bus.zero      <= !s1_special && ((s1_a_zero && s1_b_zero) || (s1_eff_sub && s1_match));
            bus.eff_sub   <= s1_eff_sub;
            bus.a_is_zero <= s1_a_zero;
            bus.b_is_zero <= s1_b_zero;
            bus.special   <= s1_special;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_count) begin
            bus.zero_count <= '0;
        end else if (out_xfer && bus.zero && (bus.zero_count != CNT_MAX)) begin
            bus.zero_count <= bus.zero_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/fp_zero_detect_pipe.md
FP_ZERO_DETECT_PIPE -- requirements
Module: fp_zero_detect_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 4, exponent field width.
REQ-002 The block SHALL have parameter MANT_W, default 5, mantissa field width.
REQ-003 The block SHALL have parameter CNT_W, default 8, zero-result counter width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  clock, rising edge
  rst  in  1  synchronous active-high reset
  in_valid  in  1  operand set present
  in_ready  out  1  block accepts operand set
  sign_a, sign_b  in  1  operand signs
  funct  in  1  0 = add, 1 = subtract (A - B)
  exp_a, exp_b  in  EXP_W  biased exponents
  mant_a, mant_b  in  MANT_W  mantissa fields
  out_valid  out  1  result flags present
  out_ready  in  1  consumer accepts flags
  zero  out  1  add/sub result is exactly zero
  eff_sub  out  1  effective operation is subtraction
  a_is_zero, b_is_zero  out  1  operand is zero (exp = 0, mant = 0)
  special  out  1  either exponent all ones (inf/NaN)
  clr_count  in  1  synchronous clear of zero_count
  zero_count  out  CNT_W  saturating count of zero results delivered

Function
REQ-006 eff_sub SHALL equal sign_a XOR sign_b XOR funct.
REQ-007 Operand zero SHALL mean exponent = 0 and mantissa = 0; sign is ignored.
REQ-008 special SHALL be 1 when exp_a or exp_b is all ones.
REQ-009 zero SHALL be 0 whenever special = 1.
REQ-010 Otherwise, zero SHALL be 1 when both operands are zero, regardless of signs and funct.
REQ-011 Otherwise, zero SHALL be 1 when eff_sub = 1, exp_a = exp_b and mant_a = mant_b.
REQ-012 In all other cases zero SHALL be 0.
REQ-013 The block SHALL be a 2-stage pipeline: stage 1 registers the compare and classify results, stage 2 registers the output flags.
REQ-014 Latency SHALL be 2 cycles from the input handshake to out_valid when out_ready is held 1.
REQ-015 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-016 Stage 2 SHALL advance when !out_valid || out_ready.
REQ-017 Stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-018 in_ready SHALL equal the stage-1 advance condition (combinational from out_ready, no skid buffer).
REQ-019 With out_ready held 1, the block SHALL accept one operand set every cycle.
REQ-020 While out_valid = 1 and out_ready = 0, all output flags SHALL hold stable.
REQ-021 Results SHALL be delivered in acceptance order, with no loss or duplication.
REQ-022 zero_count SHALL increment by 1 on each output transfer with zero = 1.
REQ-023 zero_count SHALL saturate at 2^CNT_W - 1.
REQ-024 clr_count SHALL set zero_count to 0 on the next edge.
REQ-025 When clr_count and a counting transfer occur in the same cycle, clear SHALL win and the result SHALL be 0.

Reset
REQ-026 On rst = 1 at a clock edge, both stage valids, out_valid, all flag outputs and zero_count SHALL become 0.
REQ-027 Any in-flight operand sets SHALL be discarded on reset.
REQ-028 in_ready SHALL be 1 in the cycle after reset.
REQ-029 rst SHALL take priority over clr_count and every handshake.

Structure
REQ-030 A shared package fp_pkg SHALL hold the default EXP_W, MANT_W and CNT_W values and the exp-all-ones constant function/localparam.
REQ-031 Per-operand classification (is_zero, is_special) SHALL be a sub-module fp_operand_classify, instantiated once per operand.

Verification (EXP_W = 4, MANT_W = 5 unless stated)
REQ-032 Scenario: A = +, 4'h5, 5'h13; B = +, 4'h5, 5'h13; funct = 1; out_ready = 1 -> 2 cycles later out_valid = 1, zero = 1, eff_sub = 1, zero_count = 1.
REQ-033 Scenario: same operands with funct = 0 -> zero = 0, eff_sub = 0, zero_count unchanged.
REQ-034 Scenario: exp_a = 4'hF, all other fields equal, eff_sub = 1 -> special = 1, zero = 0.
REQ-035 Scenario: A = +0, B = -0, funct = 0 -> zero = 1, a_is_zero = 1, b_is_zero = 1.
REQ-036 Scenario: three back-to-back inputs with out_ready = 0 -> in_ready = 0 after two acceptances; on out_ready = 1, three results appear in order, unchanged.
REQ-037 Scenario: CNT_W = 2, five zero-result transfers -> zero_count = 3; then clr_count together with a zero transfer -> zero_count = 0; rst asserted mid-stream -> out_valid = 0 next cycle.
